// File: rtl/ds_issue_ctrl.sv
// ds_issue_ctrl: dual-issue decision plus decode-to-execute pipeline register.
// Looks at the two FIFO head entries, tells the FIFO how many to pop, and
// registers the issued pair toward the execute stage.
module ds_issue_ctrl #(
    parameter int BUS_WD = 102
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              fifo_to_ds_valid_0,
    input  logic              fifo_to_ds_valid_1,
    input  logic [BUS_WD-1:0] fifo_to_ds_bus_0,
    input  logic [BUS_WD-1:0] fifo_to_ds_bus_1,
    input  logic              es_allowin,
    input  logic              ds_flush,
    output logic [1:0]        issue_mode,
    output logic              ds_to_es_valid_0,
    output logic              ds_to_es_valid_1,
    output logic [BUS_WD-1:0] ds_to_es_bus_0,
    output logic [BUS_WD-1:0] ds_to_es_bus_1
);

    typedef enum logic [1:0] {
        ISSUE_NONE   = 2'b00,
        ISSUE_SIGNLE = 2'b01,
        ISSUE_DUAL   = 2'b10
    } issue_mode_e;

    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_REGIMM  = 6'b000001;
    localparam logic [5:0] OP_J       = 6'b000010;
    localparam logic [5:0] OP_JAL     = 6'b000011;
    localparam logic [5:0] OP_BEQ     = 6'b000100;
    localparam logic [5:0] OP_BNE     = 6'b000101;
    localparam logic [5:0] OP_BLEZ    = 6'b000110;
    localparam logic [5:0] OP_BGTZ    = 6'b000111;
    localparam logic [5:0] OP_COP0    = 6'b010000;

    localparam logic [5:0] FN_JR      = 6'b001000;
    localparam logic [5:0] FN_JALR    = 6'b001001;
    localparam logic [5:0] FN_SYSCALL = 6'b001100;
    localparam logic [5:0] FN_BREAK   = 6'b001101;
    localparam logic [5:0] FN_ERET    = 6'b011000;

    localparam logic [4:0] RT_BLTZ    = 5'b00000;
    localparam logic [4:0] RT_BGEZ    = 5'b00001;
    localparam logic [4:0] RT_BLTZAL  = 5'b10000;
    localparam logic [4:0] RT_BGEZAL  = 5'b10001;
    localparam logic [4:0] RS_MFC0    = 5'b00000;
    localparam logic [4:0] RS_MTC0    = 5'b00100;

    // SPECIAL-encoded ALU ops: shifts, add/sub/logic, set-less-than.
    function automatic logic special_alu(input logic [5:0] fn);
        logic r;
        case (fn)
            6'b000000, 6'b000010, 6'b000011,
            6'b000100, 6'b000110, 6'b000111: r = 1'b1;
            default: r = (fn[5:3] == 3'b100) || (fn == 6'b101010) || (fn == 6'b101011);
        endcase
        return r;
    endfunction

    // Destination register; 0 means no write.
    function automatic logic [4:0] dest_of(input logic [5:0] op, input logic [4:0] rs,
                                           input logic [4:0] rt, input logic [4:0] rd,
                                           input logic [5:0] fn);
        logic [4:0] d;
        d = '0;
        case (op)
            OP_SPECIAL: if (special_alu(fn) || fn == FN_JALR) d = rd;
            OP_REGIMM:  if (rt == RT_BLTZAL || rt == RT_BGEZAL) d = 5'd31;
            OP_JAL:     d = 5'd31;
            OP_COP0:    if (rs == RS_MFC0) d = rt;
            default:    if (op[5:3] == 3'b001 || op[5:3] == 3'b100) d = rt;
        endcase
        return d;
    endfunction

    function automatic logic is_branch(input logic [5:0] op, input logic [4:0] rt,
                                       input logic [5:0] fn);
        logic b;
        case (op)
            OP_SPECIAL: b = (fn == FN_JR) || (fn == FN_JALR);
            OP_REGIMM:  b = (rt == RT_BLTZ) || (rt == RT_BGEZ) ||
                            (rt == RT_BLTZAL) || (rt == RT_BGEZAL);
            OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: b = 1'b1;
            default:    b = 1'b0;
        endcase
        return b;
    endfunction

    // HI/LO, multiply/divide, CP0 and trap instructions issue alone.
    function automatic logic is_serial(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [5:0] fn);
        logic s;
        case (op)
            OP_SPECIAL: s = (fn[5:2] == 4'b0110) || (fn[5:2] == 4'b0100) ||
                            (fn == FN_SYSCALL) || (fn == FN_BREAK);
            OP_COP0:    s = (rs == RS_MFC0) || (rs == RS_MTC0) || (rs[4] && fn == FN_ERET);
            default:    s = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic reads_reg(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] d);
        return (d != 5'd0) && (rs == d || rt == d);
    endfunction

    // Field slices of each slot's instruction word (bus bits [63:32]).
    logic [5:0] op_0, op_1, fn_0, fn_1;
    logic [4:0] rs_0, rs_1, rt_0, rt_1, rd_0, rd_1;
    assign op_0 = fifo_to_ds_bus_0[63:58];
    assign rs_0 = fifo_to_ds_bus_0[57:53];
    assign rt_0 = fifo_to_ds_bus_0[52:48];
    assign rd_0 = fifo_to_ds_bus_0[47:43];
    assign fn_0 = fifo_to_ds_bus_0[37:32];
    assign op_1 = fifo_to_ds_bus_1[63:58];
    assign rs_1 = fifo_to_ds_bus_1[57:53];
    assign rt_1 = fifo_to_ds_bus_1[52:48];
    assign rd_1 = fifo_to_ds_bus_1[47:43];
    assign fn_1 = fifo_to_ds_bus_1[37:32];

    logic [4:0] dest_0, dest_1;
    logic       ex_0, ex_1, ld_0, ld_1, mem_0, mem_1, br_0, br_1, ser_0, ser_1;
    assign dest_0 = dest_of(op_0, rs_0, rt_0, rd_0, fn_0);
    assign dest_1 = dest_of(op_1, rs_1, rt_1, rd_1, fn_1);
    assign ex_0   = fifo_to_ds_bus_0[BUS_WD-1];
    assign ex_1   = fifo_to_ds_bus_1[BUS_WD-1];
    assign ld_0   = (op_0[5:3] == 3'b100);
    assign ld_1   = (op_1[5:3] == 3'b100);
    assign mem_0  = (op_0[5:4] == 2'b10);
    assign mem_1  = (op_1[5:4] == 2'b10);
    assign br_0   = is_branch(op_0, rt_0, fn_0);
    assign br_1   = is_branch(op_1, rt_1, fn_1);
    assign ser_0  = is_serial(op_0, rs_0, fn_0);
    assign ser_1  = is_serial(op_1, rs_1, fn_1);

    // Execute-stage slot state kept for the load-use interlock.
    logic       es_load_0, es_load_1;
    logic [4:0] es_dest_0, es_dest_1;

    logic lu_0, lu_1, dep_1;
    assign lu_0  = (ds_to_es_valid_0 && es_load_0 && reads_reg(rs_0, rt_0, es_dest_0)) ||
                   (ds_to_es_valid_1 && es_load_1 && reads_reg(rs_0, rt_0, es_dest_1));
    assign lu_1  = (ds_to_es_valid_0 && es_load_0 && reads_reg(rs_1, rt_1, es_dest_0)) ||
                   (ds_to_es_valid_1 && es_load_1 && reads_reg(rs_1, rt_1, es_dest_1));
    assign dep_1 = reads_reg(rs_1, rt_1, dest_0);

    issue_mode_e mode;

    // Issue decision in priority order; a branch never leaves without its delay slot.
    always_comb begin
        mode = ISSUE_NONE;
        if (!resetn || ds_flush || !es_allowin || !fifo_to_ds_valid_0) begin
            mode = ISSUE_NONE;
        end else if (lu_0) begin
            mode = ISSUE_NONE;
        end else if (br_0) begin
            if (!fifo_to_ds_valid_1)
                mode = ISSUE_NONE;
            else if (dep_1 || lu_1 || ex_1)
                mode = ISSUE_SIGNLE;
            else
                mode = ISSUE_DUAL;
        end else if (!fifo_to_ds_valid_1 || ex_0 || ex_1 || ser_0 || ser_1 ||
                     (mem_0 && mem_1) || br_1 || dep_1 || lu_1) begin
            mode = ISSUE_SIGNLE;
        end else begin
            mode = ISSUE_DUAL;
        end
    end

    assign issue_mode = mode;

    logic take_0, take_1;
    assign take_0 = (mode != ISSUE_NONE);
    assign take_1 = (mode == ISSUE_DUAL);

    // Decode-to-execute register: flush clears, stall holds, otherwise capture the issued slots.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ds_to_es_valid_0 <= 1'b0;
            ds_to_es_valid_1 <= 1'b0;
            ds_to_es_bus_0   <= '0;
            ds_to_es_bus_1   <= '0;
            es_load_0        <= 1'b0;
            es_load_1        <= 1'b0;
            es_dest_0        <= '0;
            es_dest_1        <= '0;
        end else if (ds_flush) begin
            ds_to_es_valid_0 <= 1'b0;
            ds_to_es_valid_1 <= 1'b0;
            ds_to_es_bus_0   <= '0;
            ds_to_es_bus_1   <= '0;
            es_load_0        <= 1'b0;
            es_load_1        <= 1'b0;
            es_dest_0        <= '0;
            es_dest_1        <= '0;
        end else if (es_allowin) begin
            ds_to_es_valid_0 <= take_0;
            ds_to_es_valid_1 <= take_1;
            ds_to_es_bus_0   <= take_0 ? fifo_to_ds_bus_0 : '0;
            ds_to_es_bus_1   <= take_1 ? fifo_to_ds_bus_1 : '0;
            es_load_0        <= take_0 && ld_0;
            es_load_1        <= take_1 && ld_1;
            es_dest_0        <= take_0 ? dest_0 : '0;
            es_dest_1        <= take_1 ? dest_1 : '0;
        end
    end

endmodule

// File: tb/tb_ds_issue_ctrl.sv
// tb_ds_issue_ctrl: scoreboard bench for ds_issue_ctrl. Instructions are built
// from mnemonics; the reference model works on the mnemonic's properties.
module tb_ds_issue_ctrl;

    localparam int BUS_WD = 102;

    logic              clk = 1'b0;
    logic              resetn;
    logic              fifo_to_ds_valid_0, fifo_to_ds_valid_1;
    logic [BUS_WD-1:0] fifo_to_ds_bus_0, fifo_to_ds_bus_1;
    logic              es_allowin, ds_flush;
    logic [1:0]        issue_mode;
    logic              ds_to_es_valid_0, ds_to_es_valid_1;
    logic [BUS_WD-1:0] ds_to_es_bus_0, ds_to_es_bus_1;

    ds_issue_ctrl #(.BUS_WD(BUS_WD)) dut (
        .clk                (clk),
        .resetn             (resetn),
        .fifo_to_ds_valid_0 (fifo_to_ds_valid_0),
        .fifo_to_ds_valid_1 (fifo_to_ds_valid_1),
        .fifo_to_ds_bus_0   (fifo_to_ds_bus_0),
        .fifo_to_ds_bus_1   (fifo_to_ds_bus_1),
        .es_allowin         (es_allowin),
        .ds_flush           (ds_flush),
        .issue_mode         (issue_mode),
        .ds_to_es_valid_0   (ds_to_es_valid_0),
        .ds_to_es_valid_1   (ds_to_es_valid_1),
        .ds_to_es_bus_0     (ds_to_es_bus_0),
        .ds_to_es_bus_1     (ds_to_es_bus_1)
    );

    always #5 clk = ~clk;

    typedef enum int {
        K_ADDU, K_SLL, K_ADDIU, K_LUI, K_LW, K_LB, K_SW, K_MULT, K_MFHI, K_MFC0,
        K_SYSCALL, K_ERET, K_BEQ, K_BNE, K_BLTZ, K_BGEZAL, K_J, K_JAL, K_JR, K_JALR,
        K_NUM
    } kind_e;

    typedef struct {
        logic [BUS_WD-1:0] bus;
        bit                ex;
        bit [4:0]          rs, rt, dest;
        bit                load, mem, br, ser;
    } ent_t;

    typedef struct {
        bit                v0, v1;
        logic [BUS_WD-1:0] b0, b1;
    } snap_t;

    ent_t  fifo_q[$];
    snap_t sb_q[$];
    ent_t  es[2];
    bit    es_v[2];
    int    total = 0;
    int    bad   = 0;

    task automatic chk(input string nm, input logic [BUS_WD-1:0] act,
                       input logic [BUS_WD-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: actual=%h required=%h", nm, act, exp);
        end
    endtask

    // Assemble an instruction from its mnemonic and record what it does.
    function automatic ent_t make_ent(input kind_e k, input bit [4:0] rs, input bit [4:0] rt,
                                      input bit [4:0] rd, input bit ex);
        ent_t        e;
        logic [31:0] inst;
        logic [15:0] imm;
        bit   [4:0]  dst;
        imm = 16'($urandom);
        dst = 5'd0;
        e.load = 0; e.mem = 0; e.br = 0; e.ser = 0;
        case (k)
            K_ADDU:    begin inst = {6'd0, rs, rt, rd, 5'd0, 6'b100001}; dst = rd; end
            K_SLL:     begin inst = {6'd0, 5'd0, rt, rd, imm[4:0], 6'd0}; dst = rd; end
            K_ADDIU:   begin inst = {6'b001001, rs, rt, imm}; dst = rt; end
            K_LUI:     begin inst = {6'b001111, 5'd0, rt, imm}; dst = rt; end
            K_LW:      begin inst = {6'b100011, rs, rt, imm}; dst = rt; e.load = 1; e.mem = 1; end
            K_LB:      begin inst = {6'b100000, rs, rt, imm}; dst = rt; e.load = 1; e.mem = 1; end
            K_SW:      begin inst = {6'b101011, rs, rt, imm}; e.mem = 1; end
            K_MULT:    begin inst = {6'd0, rs, rt, 10'd0, 6'b011000}; e.ser = 1; end
            K_MFHI:    begin inst = {6'd0, 10'd0, rd, 5'd0, 6'b010000}; e.ser = 1; end
            K_MFC0:    begin inst = {6'b010000, 5'd0, rt, rd, 8'd0, 3'd0}; dst = rt; e.ser = 1; end
            K_SYSCALL: begin inst = {6'd0, rs, rt, rd, imm[4:0], 6'b001100}; e.ser = 1; end
            K_ERET:    begin inst = {6'b010000, 1'b1, 19'd0, 6'b011000}; e.ser = 1; end
            K_BEQ:     begin inst = {6'b000100, rs, rt, imm}; e.br = 1; end
            K_BNE:     begin inst = {6'b000101, rs, rt, imm}; e.br = 1; end
            K_BLTZ:    begin inst = {6'b000001, rs, 5'b00000, imm}; e.br = 1; end
            K_BGEZAL:  begin inst = {6'b000001, rs, 5'b10001, imm}; e.br = 1; dst = 5'd31; end
            K_J:       begin inst = {6'b000010, rs, rt, imm}; e.br = 1; end
            K_JAL:     begin inst = {6'b000011, rs, rt, imm}; e.br = 1; dst = 5'd31; end
            K_JR:      begin inst = {6'd0, rs, 15'd0, 6'b001000}; e.br = 1; end
            K_JALR:    begin inst = {6'd0, rs, 5'd0, rd, 5'd0, 6'b001001}; e.br = 1; dst = rd; end
            default:   inst = '0;
        endcase
        e.rs   = inst[25:21];
        e.rt   = inst[20:16];
        e.dest = dst;
        e.ex   = ex;
        e.bus  = {ex, 5'($urandom), 32'($urandom), inst, 32'($urandom)};
        return e;
    endfunction

    function automatic bit reads(input ent_t x, input bit [4:0] d);
        return (d != 5'd0) && (x.rs == d || x.rt == d);
    endfunction

    function automatic bit load_use(input ent_t x);
        for (int k = 0; k < 2; k++)
            if (es_v[k] && es[k].load && reads(x, es[k].dest)) return 1'b1;
        return 1'b0;
    endfunction

    // Reference issue count: 0, 1 or 2 instructions leave the FIFO this cycle.
    function automatic int model_mode(input bit allow, input bit flush);
        ent_t a, b;
        if (!allow || flush || fifo_q.size() == 0) return 0;
        a = fifo_q[0];
        if (load_use(a)) return 0;
        if (a.br) begin
            if (fifo_q.size() < 2) return 0;
            b = fifo_q[1];
            if (reads(b, a.dest) || load_use(b) || b.ex) return 1;
            return 2;
        end
        if (fifo_q.size() < 2) return 1;
        b = fifo_q[1];
        if (a.ex || b.ex || a.ser || b.ser || (a.mem && b.mem) || b.br ||
            reads(b, a.dest) || load_use(b)) return 1;
        return 2;
    endfunction

    task automatic drive_fifo();
        logic [127:0] junk;
        junk = {$urandom, $urandom, $urandom, $urandom};
        fifo_to_ds_valid_0 = (fifo_q.size() > 0);
        fifo_to_ds_valid_1 = (fifo_q.size() > 1);
        fifo_to_ds_bus_0   = (fifo_q.size() > 0) ? fifo_q[0].bus : junk[BUS_WD-1:0];
        fifo_to_ds_bus_1   = (fifo_q.size() > 1) ? fifo_q[1].bus : junk[BUS_WD-1:0];
    endtask

    // One cycle: drive, check issue_mode, advance the model, queue expected register state.
    task automatic step(input bit allow, input bit flush, input int exp_plan);
        int    m;
        snap_t s;
        @(negedge clk);
        es_allowin = allow;
        ds_flush   = flush;
        drive_fifo();
        #1;
        m = model_mode(allow, flush);
        chk("issue_mode", BUS_WD'(issue_mode), BUS_WD'(m));
        if (exp_plan >= 0) chk("plan_mode", BUS_WD'(issue_mode), BUS_WD'(exp_plan));
        if (flush) begin
            es_v[0] = 0;
            es_v[1] = 0;
            fifo_q.delete();
        end else if (allow) begin
            es_v[0] = (m != 0);
            es_v[1] = (m == 2);
            if (m >= 1) es[0] = fifo_q.pop_front();
            if (m == 2) es[1] = fifo_q.pop_front();
        end
        s.v0 = es_v[0];
        s.v1 = es_v[1];
        s.b0 = es[0].bus;
        s.b1 = es[1].bus;
        sb_q.push_back(s);
    endtask

    // Monitor: after each edge out of reset, compare the registered pair with the oldest expectation.
    initial begin
        snap_t s;
        forever begin
            @(posedge clk);
            #1;
            if (resetn && sb_q.size() > 0) begin
                s = sb_q.pop_front();
                chk("es_valid_0", BUS_WD'(ds_to_es_valid_0), BUS_WD'(s.v0));
                chk("es_valid_1", BUS_WD'(ds_to_es_valid_1), BUS_WD'(s.v1));
                if (s.v0) chk("es_bus_0", ds_to_es_bus_0, s.b0);
                if (s.v1) chk("es_bus_1", ds_to_es_bus_1, s.b1);
            end
        end
    end

    function automatic ent_t rand_ent();
        return make_ent(kind_e'($urandom_range(0, K_NUM - 1)), 5'($urandom_range(0, 7)),
                        5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                        ($urandom_range(0, 15) == 0));
    endfunction

    initial begin
        resetn     = 1'b0;
        es_allowin = 1'b1;
        ds_flush   = 1'b0;
        es_v[0]    = 0;
        es_v[1]    = 0;
        fifo_q.push_back(make_ent(K_ADDU, 5'd2, 5'd3, 5'd1, 0));
        fifo_q.push_back(make_ent(K_ADDU, 5'd5, 5'd6, 5'd4, 0));
        drive_fifo();
        @(posedge clk);
        #1;
        chk("rst_issue_mode", BUS_WD'(issue_mode), '0);
        chk("rst_valid_0", BUS_WD'(ds_to_es_valid_0), '0);
        chk("rst_valid_1", BUS_WD'(ds_to_es_valid_1), '0);
        chk("rst_bus_0", ds_to_es_bus_0, '0);
        chk("rst_bus_1", ds_to_es_bus_1, '0);
        @(negedge clk);
        resetn = 1'b1;

        // Independent ADDU pair dual-issues.
        step(1, 0, 2);
        step(1, 0, 0);
        // RAW inside the pair.
        fifo_q.push_back(make_ent(K_ADDU, 5'd2, 5'd3, 5'd1, 0));
        fifo_q.push_back(make_ent(K_ADDU, 5'd1, 5'd5, 5'd4, 0));
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        // Load-use: one bubble, then the dependent pair dual-issues.
        fifo_q.push_back(make_ent(K_LW, 5'd0, 5'd8, 5'd0, 0));
        step(1, 0, 1);
        fifo_q.push_back(make_ent(K_ADDU, 5'd8, 5'd0, 5'd9, 0));
        fifo_q.push_back(make_ent(K_ADDU, 5'd11, 5'd12, 5'd10, 0));
        step(1, 0, 0);
        step(1, 0, 2);
        step(1, 0, 0);
        // Branch waits for its delay slot; JAL link consumed by slot1.
        fifo_q.push_back(make_ent(K_BEQ, 5'd1, 5'd2, 5'd0, 0));
        step(1, 0, 0);
        fifo_q.push_back(make_ent(K_SLL, 5'd0, 5'd0, 5'd0, 0));
        step(1, 0, 2);
        fifo_q.push_back(make_ent(K_JAL, 5'd0, 5'd0, 5'd0, 0));
        fifo_q.push_back(make_ent(K_ADDU, 5'd31, 5'd0, 5'd2, 0));
        fifo_q.push_back(make_ent(K_SLL, 5'd0, 5'd0, 5'd0, 0));
        step(1, 0, 1);
        step(1, 0, 2);
        step(1, 0, 0);
        // Structural / ordering restrictions.
        fifo_q.push_back(make_ent(K_LW, 5'd9, 5'd8, 5'd0, 0));
        fifo_q.push_back(make_ent(K_SW, 5'd11, 5'd10, 5'd0, 0));
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        fifo_q.push_back(make_ent(K_MULT, 5'd2, 5'd3, 5'd0, 0));
        fifo_q.push_back(make_ent(K_ADDU, 5'd5, 5'd6, 5'd4, 0));
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        fifo_q.push_back(make_ent(K_ADDU, 5'd2, 5'd3, 5'd1, 0));
        fifo_q.push_back(make_ent(K_BNE, 5'd4, 5'd5, 5'd0, 0));
        fifo_q.push_back(make_ent(K_SLL, 5'd0, 5'd0, 5'd0, 0));
        step(1, 0, 1);
        step(1, 0, 2);
        step(1, 0, 0);
        // Exception-tagged entries.
        fifo_q.push_back(make_ent(K_BEQ, 5'd1, 5'd2, 5'd0, 0));
        fifo_q.push_back(make_ent(K_ADDU, 5'd4, 5'd5, 5'd3, 1));
        step(1, 0, 1);
        step(1, 0, 1);
        fifo_q.push_back(make_ent(K_ADDU, 5'd2, 5'd3, 5'd1, 1));
        fifo_q.push_back(make_ent(K_ADDU, 5'd5, 5'd6, 5'd4, 0));
        step(1, 0, 1);
        step(1, 0, 1);
        step(1, 0, 0);
        // Flush while ES holds a valid pair.
        fifo_q.push_back(make_ent(K_ADDU, 5'd2, 5'd3, 5'd1, 0));
        fifo_q.push_back(make_ent(K_ADDU, 5'd5, 5'd6, 5'd4, 0));
        step(1, 0, 2);
        fifo_q.push_back(make_ent(K_ADDU, 5'd2, 5'd3, 5'd7, 0));
        fifo_q.push_back(make_ent(K_ADDU, 5'd5, 5'd6, 5'd9, 0));
        step(1, 1, 0);
        step(1, 0, 0);
        // Stall concurrent with load-use: interlock persists against the held pair.
        fifo_q.push_back(make_ent(K_LW, 5'd0, 5'd8, 5'd0, 0));
        step(1, 0, 1);
        fifo_q.push_back(make_ent(K_ADDU, 5'd8, 5'd0, 5'd9, 0));
        step(0, 0, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(1, 0, 1);
        step(1, 0, 0);

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            while (fifo_q.size() < 4 && $urandom_range(0, 2) != 0) fifo_q.push_back(rand_ent());
            step($urandom_range(0, 7) != 0, $urandom_range(0, 31) == 0, -1);
        end

        // Asynchronous reset in the middle of traffic.
        fifo_q.delete();
        fifo_q.push_back(make_ent(K_ADDU, 5'd0, 5'd0, 5'd1, 0));
        fifo_q.push_back(make_ent(K_ADDU, 5'd0, 5'd0, 5'd2, 0));
        step(1, 0, 2);
        fifo_q.push_back(make_ent(K_ADDU, 5'd0, 5'd0, 5'd3, 0));
        fifo_q.push_back(make_ent(K_ADDU, 5'd0, 5'd0, 5'd4, 0));
        @(posedge clk);
        #2;
        es_allowin = 1'b1;
        ds_flush   = 1'b0;
        drive_fifo();
        resetn = 1'b0;
        #1;
        chk("async_issue_mode", BUS_WD'(issue_mode), '0);
        chk("async_valid_0", BUS_WD'(ds_to_es_valid_0), '0);
        chk("async_valid_1", BUS_WD'(ds_to_es_valid_1), '0);
        chk("async_bus_0", ds_to_es_bus_0, '0);
        chk("async_bus_1", ds_to_es_bus_1, '0);
        es_v[0] = 0;
        es_v[1] = 0;
        @(negedge clk);
        @(negedge clk);
        resetn = 1'b1;
        step(1, 0, 2);
        step(1, 0, 0);
        repeat (3) @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
